// File: rtl/issue_scheduler_if.sv
// Issue-stage bus between the decoder/fetch side and the issue scheduler.
//   master : decoder/fetch side (drives instruction and branch-resolution inputs)
//   slave  : issue_scheduler (drives stall, issue, ctrl_out, flush, stall_count)
// Signals:
//   instr_valid  decoded instruction present this cycle
//   ctrl_in      32-bit decoder control word
//   jmp_flag     current instruction is a JMP
//   br_resolved  outstanding BNE evaluated (1-cycle pulse)
//   br_taken     BNE outcome, meaningful only with br_resolved
//   stall        combinational hold request to fetch
//   issue        registered: ctrl_out carries a real instruction
//   ctrl_out     registered control word to datapath, zero on bubble
//   flush        registered 1-cycle fetch discard pulse
//   stall_count  saturating count of stall cycles
interface issue_scheduler_if #(
    parameter int unsigned CNT_W = 16
);
    logic             instr_valid;
    logic [31:0]      ctrl_in;
    logic             jmp_flag;
    logic             br_resolved;
    logic             br_taken;
    logic             stall;
    logic             issue;
    logic [31:0]      ctrl_out;
    logic             flush;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output instr_valid, ctrl_in, jmp_flag, br_resolved, br_taken,
        input  stall, issue, ctrl_out, flush, stall_count
    );

    modport slave (
        input  instr_valid, ctrl_in, jmp_flag, br_resolved, br_taken,
        output stall, issue, ctrl_out, flush, stall_count
    );
endinterface

// File: rtl/issue_scheduler.sv
// Issue-stage scheduler: issues the decoder's ctrl word or inserts a bubble.
// Blocks RAW hazards against in-flight register-file writes, holds issue while
// a BNE resolves, and pulses flush after a JMP or a taken branch.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  issue_scheduler_if.slave (instruction in, ctrl/issue/flush/stall out)
// Parameters:
//   DEPTH  cycles from issue to register-file writeback (1..8)
//   CNT_W  width of the saturating stall counter
module issue_scheduler #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input logic              clk,
    input logic              rst,
    issue_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_BR = 2'd1,
        FLUSH   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             issue_q, issue_d;
    logic [31:0]      ctrl_q, ctrl_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0] sb_vld_q, sb_vld_d;
    logic [4:0]       sb_rd_q [DEPTH];
    logic [4:0]       sb_rd_d [DEPTH];

    logic       stall;
    logic       raw_hit;
    logic       rt_used;
    logic [4:0] rs, rt, rd;
    logic       we_rf, sel_mux2, branch;

    assign rs       = bus.ctrl_in[31:27];
    assign rt       = bus.ctrl_in[26:22];
    assign rd       = bus.ctrl_in[21:17];
    assign we_rf    = bus.ctrl_in[13];
    assign sel_mux2 = bus.ctrl_in[11];
    assign branch   = bus.ctrl_in[9];

    // Immediate-form writers (LW/ADDI/ORI) use rt as destination, not source.
    assign rt_used = !(sel_mux2 && we_rf);

    // r0 never enters the scoreboard, but the source checks still exclude it
    // so a stray rd=0 entry could never cause a spurious stall.
    always_comb begin
        raw_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sb_vld_q[i]) begin
                if ((rs != 5'd0) && (sb_rd_q[i] == rs)) begin
                    raw_hit = 1'b1;
                end
                if (rt_used && (rt != 5'd0) && (sb_rd_q[i] == rt)) begin
                    raw_hit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        issue_d = 1'b0;
        ctrl_d  = '0;
        flush_d = 1'b0;
        unique case (state_q)
            RUN: begin
                stall = bus.instr_valid && raw_hit;
                if (bus.instr_valid && !raw_hit) begin
                    issue_d = 1'b1;
                    ctrl_d  = bus.ctrl_in;
                    if (branch) begin
                        state_d = WAIT_BR;
                    end else if (bus.jmp_flag) begin
                        // flush rises together with entry into FLUSH
                        state_d = FLUSH;
                        flush_d = 1'b1;
                    end
                end
            end
            WAIT_BR: begin
                stall = 1'b1;
                if (bus.br_resolved) begin
                    flush_d = bus.br_taken;
                    state_d = RUN;
                end
            end
            FLUSH: begin
                stall   = 1'b1;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Scoreboard shifts every cycle; the oldest entry falls off as its write completes.
    always_comb begin
        sb_vld_d[0] = issue_d && we_rf && (rd != 5'd0);
        sb_rd_d[0]  = rd;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            sb_vld_d[i] = sb_vld_q[i-1];
            sb_rd_d[i]  = sb_rd_q[i-1];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            issue_q  <= 1'b0;
            ctrl_q   <= '0;
            flush_q  <= 1'b0;
            cnt_q    <= '0;
            sb_vld_q <= '0;
            sb_rd_q  <= '{default: '0};
        end else begin
            state_q  <= state_d;
            issue_q  <= issue_d;
            ctrl_q   <= ctrl_d;
            flush_q  <= flush_d;
            cnt_q    <= cnt_d;
            sb_vld_q <= sb_vld_d;
            sb_rd_q  <= sb_rd_d;
        end
    end

    assign bus.stall       = stall;
    assign bus.issue       = issue_q;
    assign bus.ctrl_out    = ctrl_q;
    assign bus.flush       = flush_q;
    assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Testbench for issue_scheduler: directed instruction sequences, expected issue
// and flush events queued by the stimulus and checked by an independent monitor.
module tb_issue_scheduler;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [31:0] ctrl;
        int          cyc;
    } iss_t;

    iss_t iss_q[$];
    int   fl_q[$];

    issue_scheduler_if #(.CNT_W(CNT_W)) bus ();

    issue_scheduler #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mk(input int rs, input int rt, input int rd,
                                       input bit we_rf, input bit sel2, input bit br);
        logic [31:0] w;
        w        = '0;
        w[31:27] = rs[4:0];
        w[26:22] = rt[4:0];
        w[21:17] = rd[4:0];
        w[13]    = we_rf;
        w[11]    = sel2;
        w[9]     = br;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] c, input logic j);
        bus.instr_valid = v;
        bus.ctrl_in     = c;
        bus.jmp_flag    = j;
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_stall(input logic exp);
        #1;
        chk("stall", {31'd0, bus.stall}, {31'd0, exp});
    endtask

    task automatic chk_cnt(input int exp);
        chk("stall_count", {{(32-CNT_W){1'b0}}, bus.stall_count}, exp);
    endtask

    task automatic push_iss(input logic [31:0] c, input int at);
        iss_t e;
        e.ctrl = c;
        e.cyc  = at;
        iss_q.push_back(e);
    endtask

    task automatic chk_reset_state();
        chk("rst_issue", {31'd0, bus.issue}, 32'd0);
        chk("rst_ctrl_out", bus.ctrl_out, 32'd0);
        chk("rst_flush", {31'd0, bus.flush}, 32'd0);
        chk_cnt(0);
        chk_stall(1'b0);
    endtask

    // Monitor: compares every presented issue/flush against the queued expectations.
    always @(negedge clk) begin
        iss_t e;
        if (bus.issue === 1'b1) begin
            checks++;
            if (iss_q.size() == 0) begin
                failures++;
                $display("FAIL issue_unexpected: got ctrl=%h at cyc %0d expected no issue", bus.ctrl_out, cyc);
            end else begin
                e = iss_q.pop_front();
                if (bus.ctrl_out !== e.ctrl || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL issue: got ctrl=%h cyc=%0d expected ctrl=%h cyc=%0d", bus.ctrl_out, cyc, e.ctrl, e.cyc);
                end
            end
        end else begin
            checks++;
            if (bus.ctrl_out !== 32'd0) begin
                failures++;
                $display("FAIL bubble_ctrl: got %h expected 0 at cyc %0d", bus.ctrl_out, cyc);
            end
            if (iss_q.size() > 0 && iss_q[0].cyc <= cyc) begin
                e = iss_q.pop_front();
                checks++;
                failures++;
                $display("FAIL issue_missing: got none expected ctrl=%h at cyc %0d", e.ctrl, e.cyc);
            end
        end
        if (bus.flush === 1'b1) begin
            checks++;
            if (fl_q.size() == 0) begin
                failures++;
                $display("FAIL flush_unexpected: got flush at cyc %0d expected none", cyc);
            end else if (fl_q[0] != cyc) begin
                failures++;
                $display("FAIL flush: got cyc %0d expected cyc %0d", cyc, fl_q[0]);
                void'(fl_q.pop_front());
            end else begin
                void'(fl_q.pop_front());
            end
        end else if (fl_q.size() > 0 && fl_q[0] <= cyc) begin
            checks++;
            failures++;
            $display("FAIL flush_missing: got none expected flush at cyc %0d", fl_q[0]);
            void'(fl_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] addi5, add6, addi6, addi5b, addi0, add2;
        logic [31:0] add7, add9, sub8, bne, add10, add11, add13, rd13;

        addi5  = mk(1, 5, 5, 1'b1, 1'b1, 1'b0);
        add6   = mk(5, 1, 6, 1'b1, 1'b0, 1'b0);
        addi6  = mk(0, 6, 6, 1'b1, 1'b1, 1'b0);
        addi5b = mk(0, 5, 5, 1'b1, 1'b1, 1'b0);
        addi0  = mk(1, 0, 0, 1'b1, 1'b1, 1'b0);
        add2   = mk(0, 0, 2, 1'b1, 1'b0, 1'b0);
        add7   = mk(1, 2, 7, 1'b1, 1'b0, 1'b0);
        add9   = mk(1, 2, 9, 1'b1, 1'b0, 1'b0);
        sub8   = mk(3, 7, 8, 1'b1, 1'b0, 1'b0);
        bne    = mk(1, 2, 0, 1'b0, 1'b0, 1'b1);
        add10  = mk(1, 2, 10, 1'b1, 1'b0, 1'b0);
        add11  = mk(1, 2, 11, 1'b1, 1'b0, 1'b0);
        add13  = mk(1, 2, 13, 1'b1, 1'b0, 1'b0);
        rd13   = mk(13, 1, 14, 1'b1, 1'b0, 1'b0);

        drive(1'b0, '0, 1'b0);
        bus.br_resolved = 1'b0;
        bus.br_taken    = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_reset_state();

        // RAW on rs: ADD stalls DEPTH cycles behind ADDI r5
        drive(1'b1, addi5, 1'b0); push_iss(addi5, cyc + 1); tick();
        drive(1'b1, add6, 1'b0);  push_iss(add6, cyc + 5);
        for (int k = 0; k < 5; k++) begin
            chk_stall(k < 4);
            tick();
        end
        idle(DEPTH + 1);
        chk_cnt(4);

        // rt is a destination for immediate writers: no stall
        drive(1'b1, addi5, 1'b0); push_iss(addi5, cyc + 1); tick();
        drive(1'b1, addi6, 1'b0); chk_stall(1'b0); push_iss(addi6, cyc + 1); tick();
        drive(1'b1, addi5b, 1'b0); chk_stall(1'b0); push_iss(addi5b, cyc + 1); tick();
        idle(DEPTH + 1);
        chk_cnt(4);

        // r0 never a hazard
        drive(1'b1, addi0, 1'b0); push_iss(addi0, cyc + 1); tick();
        drive(1'b1, add2, 1'b0);  chk_stall(1'b0); push_iss(add2, cyc + 1); tick();
        idle(DEPTH + 1);
        chk_cnt(4);

        // RAW on rt two slots deep: stalls DEPTH-1 cycles
        drive(1'b1, add7, 1'b0); push_iss(add7, cyc + 1); tick();
        drive(1'b1, add9, 1'b0); push_iss(add9, cyc + 1); tick();
        drive(1'b1, sub8, 1'b0); push_iss(sub8, cyc + 4);
        for (int k = 0; k < 4; k++) begin
            chk_stall(k < 3);
            tick();
        end
        idle(DEPTH + 1);
        chk_cnt(7);

        // taken BNE resolved after 3 cycles
        drive(1'b1, bne, 1'b0); push_iss(bne, cyc + 1); tick();
        drive(1'b1, add10, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                bus.br_resolved = 1'b1;
                bus.br_taken    = 1'b1;
                fl_q.push_back(cyc + 1);
            end
            chk_stall(1'b1);
            tick();
        end
        bus.br_resolved = 1'b0;
        bus.br_taken    = 1'b0;
        drive(1'b0, '0, 1'b0);
        chk_stall(1'b0);
        tick();
        chk_cnt(10);

        // br_resolved in RUN is ignored
        bus.br_resolved = 1'b1;
        bus.br_taken    = 1'b1;
        tick();
        bus.br_resolved = 1'b0;
        bus.br_taken    = 1'b0;
        idle(2);

        // not-taken BNE: no flush, held instruction issues right after
        drive(1'b1, bne, 1'b0); push_iss(bne, cyc + 1); tick();
        drive(1'b1, add11, 1'b0);
        bus.br_resolved = 1'b1;
        bus.br_taken    = 1'b0;
        chk_stall(1'b1);
        tick();
        bus.br_resolved = 1'b0;
        chk_stall(1'b0);
        push_iss(add11, cyc + 1);
        tick();
        idle(DEPTH + 1);
        chk_cnt(11);

        // JMP: issues, flush with FLUSH entry, one stall cycle
        drive(1'b1, '0, 1'b1); push_iss('0, cyc + 1); fl_q.push_back(cyc + 1); tick();
        drive(1'b0, '0, 1'b0);
        chk_stall(1'b1);
        tick();
        chk_stall(1'b0);
        chk_cnt(12);

        // counter saturates at all-ones
        drive(1'b1, bne, 1'b0); push_iss(bne, cyc + 1); tick();
        drive(1'b0, '0, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        bus.br_resolved = 1'b1;
        bus.br_taken    = 1'b0;
        tick();
        bus.br_resolved = 1'b0;
        chk_cnt(15);
        idle(2);

        // reset during FLUSH discards everything, including in-flight r13
        drive(1'b1, add13, 1'b0); push_iss(add13, cyc + 1); tick();
        drive(1'b1, '0, 1'b1); push_iss('0, cyc + 1); fl_q.push_back(cyc + 1); tick();
        drive(1'b0, '0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state();
        drive(1'b1, rd13, 1'b0);
        chk_stall(1'b0);
        push_iss(rd13, cyc + 1);
        tick();
        idle(DEPTH + 2);

        chk("iss_queue_empty", iss_q.size(), 32'd0);
        chk("flush_queue_empty", fl_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
